// File: rtl/shift_count_pkg.sv
// -----------------------------------------------------------------------------
// shift_count_pkg
// Shared encodings for the shift/count register datapath.
//   op_e    : 3-bit operation code presented on shift_count_reg.op
//   state_e : controller state (IDLE waits for start, SHIFT runs a
//             multi-cycle shift one bit per clock)
// -----------------------------------------------------------------------------
package shift_count_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_INC  = 3'b110,
    OP_DEC  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : shift_count_pkg

// File: rtl/register_en_r.sv
// -----------------------------------------------------------------------------
// register_en_r
// WIDTH-bit storage register with synchronous active-low reset and a load
// enable. Holds the value when en is low.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset (clears to zero)
//   en       load enable
//   d        next value, captured when en=1
//   q        stored value
// -----------------------------------------------------------------------------
module register_en_r #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule : register_en_r

// File: rtl/shift_count_reg.sv
// -----------------------------------------------------------------------------
// shift_count_reg
// WIDTH-bit register that loads, shifts by a programmable amount (one bit per
// clock), and counts up/down with a terminal-count pulse.
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// block is idle (busy=0); op/d/shamt are sampled on that edge only. While
// busy=1 start is ignored and not queued. done pulses for one cycle after the
// operation's last register update, and a new start may be accepted in that
// same cycle.
//
// Optional feature macro: SHIFT_COUNT_ROTATE_EN
//   defined   : op 101 rotates left
//   undefined : op 101 behaves as NOP and no rotate logic is built
//
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   start, op     request and operation code (shift_count_pkg::op_e)
//   d             parallel load data
//   shamt         shift count (values above WIDTH clamp to WIDTH)
//   si            serial input, sampled on every shift edge
//   q             register contents
//   so            last bit shifted out (held until the next shift)
//   busy          multi-cycle shift in progress
//   done          one-cycle completion pulse
//   tc            one-cycle counter wrap pulse, coincident with done
//   dbg_state     current controller state (0 = IDLE, 1 = SHIFT)
// -----------------------------------------------------------------------------
module shift_count_reg
  import shift_count_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   d,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               si,
  output logic [WIDTH-1:0]   q,
  output logic               so,
  output logic               busy,
  output logic               done,
  output logic               tc,
  output logic               dbg_state
);

  localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);
  localparam logic [WIDTH-1:0]   Q_ONE   = WIDTH'(1);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic               so_q, so_d;
  logic               done_q, done_d;
  logic               tc_q, tc_d;

  logic               q_en;
  logic [WIDTH-1:0]   q_nxt;
  logic [WIDTH:0]     shift_res;
  op_e                op_in;

  // True for ops that take the multi-cycle SHIFT path.
  function automatic logic is_shift_op(input op_e o);
    logic r;
    r = 1'b0;
    case (o)
      OP_LSL, OP_LSR, OP_ASR: r = 1'b1;
`ifdef SHIFT_COUNT_ROTATE_EN
      OP_ROL:                 r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // One-bit shift step; returns {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] shift_once(input op_e o,
                                                input logic [WIDTH-1:0] v,
                                                input logic s);
    logic [WIDTH:0] r;
    r = {1'b0, v};
    case (o)
      OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], s};
      OP_LSR:  r = {v[0], s, v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`ifdef SHIFT_COUNT_ROTATE_EN
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
`endif
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  assign op_in     = op_e'(op);
  assign shift_res = shift_once(op_q, q, si);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    so_d    = so_q;
    done_d  = 1'b0;
    tc_d    = 1'b0;
    q_en    = 1'b0;
    q_nxt   = q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_op(op_in) && (shamt != '0)) begin
            // Register stays put on the acceptance edge; shifting starts
            // on the following edge with the latched op.
            op_d    = op_in;
            cnt_d   = (shamt > WIDTH_C) ? WIDTH_C : shamt;
            state_d = ST_SHIFT;
          end else begin
            // Single-cycle ops, zero-length shifts, and (when rotate is
            // compiled out) ROL all complete here.
            done_d = 1'b1;
            case (op_in)
              OP_LOAD: begin
                q_en  = 1'b1;
                q_nxt = d;
              end
              OP_INC: begin
                q_en  = 1'b1;
                q_nxt = q + Q_ONE;
                tc_d  = &q;
              end
              OP_DEC: begin
                q_en  = 1'b1;
                q_nxt = q - Q_ONE;
                tc_d  = ~|q;
              end
              default: begin
                q_en  = 1'b0;
              end
            endcase
          end
        end
      end

      ST_SHIFT: begin
        q_en  = 1'b1;
        q_nxt = shift_res[WIDTH-1:0];
        so_d  = shift_res[WIDTH];
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      so_q    <= so_d;
      done_q  <= done_d;
      tc_q    <= tc_d;
    end
  end

  register_en_r #(
    .WIDTH (WIDTH)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (q_en),
    .d       (q_nxt),
    .q       (q)
  );

  assign so        = so_q;
  assign busy      = (state_q == ST_SHIFT);
  assign done      = done_q;
  assign tc        = tc_q;
  assign dbg_state = state_q;

endmodule : shift_count_reg

// File: tb/tb_shift_count_reg.sv
// -----------------------------------------------------------------------------
// tb_shift_count_reg
// Self-checking bench for shift_count_reg (WIDTH=8). The reference model
// treats the register as an integer 0..255 and applies each operation with
// plain arithmetic; expected shift steps are queued in exp_q and popped on
// each shift edge. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_shift_count_reg;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = $clog2(WIDTH) + 1;

`ifdef SHIFT_COUNT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   d;
  logic [SHAMT_W-1:0] shamt;
  logic               si;
  logic [WIDTH-1:0]   q;
  logic               so;
  logic               busy;
  logic               done;
  logic               tc;
  logic               dbg_state;

  int checks;
  int errors;

  // model state
  int m_q;
  int m_so;

  // expected {so, q} after each shift edge
  logic [8:0] exp_q[$];

  shift_count_reg #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .d         (d),
    .shamt     (shamt),
    .si        (si),
    .q         (q),
    .so        (so),
    .busy      (busy),
    .done      (done),
    .tc        (tc),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- model ----------------
  function automatic bit model_is_shift(input int o);
    return (o == 2) || (o == 3) || (o == 4) || ((o == 5) && ROT_EN);
  endfunction

  // Apply one shift step to (v, s_out) with serial-in b.
  task automatic model_step(input int o, input int b, inout int v, inout int s_out);
    int t;
    t = v;
    case (o)
      2: begin s_out = t / 128; v = (t * 2 + b) % 256; end
      3: begin s_out = t % 2;   v = t / 2 + b * 128; end
      4: begin s_out = t % 2;   v = t / 2 + (t / 128) * 128; end
      5: begin s_out = t / 128; v = (t * 2) % 256 + t / 128; end
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // si_sel: 0/1 fixed serial input, 2 random per shift edge.
  // poke: drive start with garbage inputs while busy (must be ignored).
  task automatic run_op(input int op_v, input int d_v, input int sh_v,
                        input int si_sel, input bit poke);
    int n;
    int exp_tc;
    int sv;
    int so_t;
    int si_b[$];
    logic [8:0] e;
    n = 0;
    exp_tc = 0;
    if (model_is_shift(op_v)) n = (sh_v > WIDTH) ? WIDTH : sh_v;

    @(negedge clk);
    start = 1'b1;
    op    = 3'(op_v);
    d     = 8'(d_v);
    shamt = SHAMT_W'(sh_v);
    si    = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    start = 1'b0;

    if (n == 0) begin
      case (op_v)
        1: m_q = d_v;
        6: begin exp_tc = (m_q == 255); m_q = (m_q + 1) % 256; end
        7: begin exp_tc = (m_q == 0);   m_q = (m_q + 255) % 256; end
        default: ;
      endcase
      checks++;
      if (q !== 8'(m_q)) begin
        errors++;
        $display("FAIL single_q op=%0d got=%h exp=%h", op_v, q, 8'(m_q));
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_done op=%0d got done=%b busy=%b exp done=1 busy=0", op_v, done, busy);
      end
      checks++;
      if (tc !== 1'(exp_tc) || so !== 1'(m_so)) begin
        errors++;
        $display("FAIL single_tc_so op=%0d got tc=%b so=%b exp tc=%0d so=%0d", op_v, tc, so, exp_tc, m_so);
      end
    end else begin
      // build scoreboard for the whole shift
      sv = m_q;
      so_t = m_so;
      for (int k = 0; k < n; k++) begin
        si_b.push_back((si_sel == 2) ? int'($urandom_range(0, 1)) : si_sel);
        model_step(op_v, si_b[k], sv, so_t);
        exp_q.push_back({1'(so_t), 8'(sv)});
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== 8'(m_q)) begin
        errors++;
        $display("FAIL accept op=%0d got busy=%b done=%b q=%h exp busy=1 done=0 q=%h", op_v, busy, done, q, 8'(m_q));
      end
      for (int k = 1; k <= n; k++) begin
        si = 1'(si_b[k-1]);
        if (poke) begin
          start = 1'b1;
          op    = 3'($urandom_range(0, 7));
          d     = 8'($urandom_range(0, 255));
          shamt = SHAMT_W'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        if (k == n) start = 1'b0;
        e = exp_q.pop_front();
        m_q  = int'(e[7:0]);
        m_so = int'(e[8]);
        checks++;
        if (q !== e[7:0] || so !== e[8]) begin
          errors++;
          $display("FAIL shift_step op=%0d k=%0d got q=%h so=%b exp q=%h so=%b", op_v, k, q, so, e[7:0], e[8]);
        end
        checks++;
        if (k < n) begin
          if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL shift_busy op=%0d k=%0d got busy=%b done=%b exp busy=1 done=0", op_v, k, busy, done);
          end
        end else begin
          if (busy !== 1'b0 || done !== 1'b1 || tc !== 1'b0) begin
            errors++;
            $display("FAIL shift_done op=%0d got busy=%b done=%b tc=%b exp busy=0 done=1 tc=0", op_v, busy, done, tc);
          end
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    start = 1'b0; op = '0; d = '0; shamt = '0; si = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_q = 0; m_so = 0;
    checks++;
    if (q !== 8'h00 || so !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset got q=%h so=%b busy=%b done=%b tc=%b st=%b exp all 0", q, so, busy, done, tc, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_lsl;
    run_op(1, 8'hA5, 0, 0, 1'b0);
    run_op(2, 0, 3, 1, 1'b0);
    checks++;
    if (q !== 8'h2F || so !== 1'b1) begin
      errors++;
      $display("FAIL lsl3 got q=%h so=%b exp q=2f so=1", q, so);
    end
  endtask

  task automatic test_asr_ignore;
    run_op(1, 8'h90, 0, 0, 1'b0);
    run_op(4, 0, 2, 2, 1'b1);
    checks++;
    if (q !== 8'hE4 || so !== 1'b0) begin
      errors++;
      $display("FAIL asr2 got q=%h so=%b exp q=e4 so=0", q, so);
    end
  endtask

  task automatic test_inc_dec_wrap;
    run_op(1, 8'hFF, 0, 0, 1'b0);
    run_op(6, 0, 0, 0, 1'b0);
    checks++;
    if (q !== 8'h00 || tc !== 1'b1) begin
      errors++;
      $display("FAIL inc_wrap got q=%h tc=%b exp q=00 tc=1", q, tc);
    end
    run_op(7, 0, 0, 0, 1'b0);
    checks++;
    if (q !== 8'hFF || tc !== 1'b1) begin
      errors++;
      $display("FAIL dec_wrap got q=%h tc=%b exp q=ff tc=1", q, tc);
    end
    // non-wrapping count: tc must stay low
    run_op(7, 0, 0, 0, 1'b0);
  endtask

  task automatic test_lsr_clamp;
    run_op(1, 8'hFF, 0, 0, 1'b0);
    run_op(3, 0, 12, 0, 1'b0);
    checks++;
    if (q !== 8'h00 || so !== 1'b1) begin
      errors++;
      $display("FAIL lsr_clamp got q=%h so=%b exp q=00 so=1", q, so);
    end
  endtask

  task automatic test_rol;
    run_op(1, 8'hA5, 0, 0, 1'b0);
    run_op(5, 0, 4, 2, 1'b0);
    checks++;
    if (q !== (ROT_EN ? 8'h5A : 8'hA5)) begin
      errors++;
      $display("FAIL rol4 got q=%h exp q=%h", q, ROT_EN ? 8'h5A : 8'hA5);
    end
  endtask

  task automatic test_reset_mid_shift;
    run_op(1, 8'h3C, 0, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; shamt = SHAMT_W'(6); si = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift_busy got busy=%b exp 1", busy);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    m_q = 0; m_so = 0;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || so !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift got q=%h busy=%b done=%b so=%b tc=%b exp all 0", q, busy, done, so, tc);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("FAIL after_reset_idle got busy=%b done=%b q=%h exp busy=0 done=0 q=00", busy, done, q);
    end
  endtask

  task automatic test_back_to_back;
    run_op(1, 8'hFD, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) run_op(6, 0, 0, 0, 1'b0);
    run_op(2, 0, 0, 0, 1'b0);   // zero-length shift completes in one cycle
    run_op(3, 0, 1, 2, 1'b0);
    run_op(7, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_lsl();
    test_asr_ignore();
    test_inc_dec_wrap();
    test_lsr_clamp();
    test_rol();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_count_reg

// File: doc/shift_count_reg.md
# shift_count_reg

Parametrised successor to the 8-bit resettable register: a WIDTH-bit register built from resettable flip-flop storage that loads, shifts (logical/arithmetic/rotate) by a programmable amount over multiple cycles, and counts up/down with terminal-count flagging. It sits in the shifter/counter datapath, driven by a controller through a start/busy/done handshake. Serial input and output allow chaining instances.

## Interface
- WIDTH, 8: register width, >= 2
- SHAMT_W, $clog2(WIDTH)+1: shift-amount width
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- op  input  3  operation, sampled on acceptance
- d  input  WIDTH  parallel load data
- shamt  input  SHAMT_W  shift count, sampled on acceptance
- si  input  1  serial-in bit, sampled on every shift edge
- q  output  WIDTH  register contents
- so  output  1  last bit shifted out (registered)
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle completion pulse
- tc  output  1  one-cycle counter wrap pulse

## Operation
- Ops: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR, 101 ROL, 110 INC, 111 DEC.
- LSL: q <= {q[WIDTH-2:0], si}; so <= q[WIDTH-1].
- LSR: q <= {si, q[WIDTH-1:1]}; so <= q[0].
- ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; so <= q[0]; si ignored.
- ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; so <= q[WIDTH-1].
- INC/DEC: modulo 2^WIDTH; tc pulses when INC wraps all-ones -> 0 or DEC wraps 0 -> all-ones.
- FSM states IDLE, SHIFT.
  - IDLE, start=1, single-cycle op (NOP/LOAD/INC/DEC) or shift op with shamt=0: q updated on that edge, stay IDLE, done=1 next cycle.
  - IDLE, start=1, shift op with shamt>0: latch op, cnt <= min(shamt, WIDTH), go SHIFT; q unchanged on acceptance edge.
  - SHIFT: one shift per edge, cnt decrements; at edge with cnt==1, last shift, go IDLE, done <= 1.
- start while busy: ignored, not queued. d/shamt/op changes while busy: no effect.
- shamt > WIDTH clamps to WIDTH.

## Timing
- Reset (sync, any state, including mid-shift): q=0, so=0, busy=0, done=0, tc=0, state IDLE, cnt=0.
- Single-cycle op: result on q and done=1 in cycle after acceptance edge; tc coincident with done.
- Shift by N>0: busy=1 for N cycles starting cycle after acceptance; q changes on each of those N edges; done=1 in the cycle after the last shift (busy=0 there). Acceptance-to-done latency N+1 cycles.
- Next start accepted in the same cycle done is high.
- so holds until next shift; unchanged by LOAD/INC/DEC/NOP.

## Configuration
- SHIFT_COUNT_ROTATE_EN defined: op 101 performs ROL as above.
- Undefined: op 101 behaves as NOP (q, so unchanged, no busy, done pulses next cycle); rotate logic absent.

## Structure
- Package shift_count_pkg: op encoding enum (OP_NOP..OP_DEC), FSM state enum (ST_IDLE, ST_SHIFT).
- Sub-module register_en_r: WIDTH-parametrised storage, sync active-low reset, load enable; holds q. Next-state and FSM logic in top.

## Test plan
- Reset asserted with busy high mid-shift -> next cycle q=0, busy=0, done=0, so=0.
- LOAD d=8'hA5 -> q=8'hA5, done=1 one cycle after acceptance; then LSL shamt=3 si=1 -> q steps 4B, 97, 2F; busy 3 cycles; done next cycle; so=1.
- q=8'h90, ASR shamt=2 -> q=C8 then E4, so=0; start pulsed while busy ignored.
- q=8'hFF, INC -> q=00, tc=1, done=1 same cycle; q=00, DEC -> q=FF, tc=1.
- LSR shamt=12 (>WIDTH) si=0 on q=8'hFF -> busy exactly 8 cycles, q=00, so=1.
- With SHIFT_COUNT_ROTATE_EN: q=A5, ROL 4 -> q=5A. Without: ROL -> q stays A5, busy never asserts, done pulses.
